// File: rtl/sim_console_if.sv
// rtl/sim_console_if.sv - register bus, byte stream and exit signals of the sim console
interface sim_console_if;
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        exit_valid;
    logic [7:0]  exit_code;

    modport master (
        output cs, we, addr, wdata, tx_ready,
        input  rdata, tx_valid, tx_data, exit_valid, exit_code
    );

    modport slave (
        input  cs, we, addr, wdata, tx_ready,
        output rdata, tx_valid, tx_data, exit_valid, exit_code
    );
endinterface

// File: rtl/sim_console.sv
// rtl/sim_console.sv - buffered memory-mapped character console with paced drain and exit register (optional print: SIM_CONSOLE_PRINT_EN)
module sim_console #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DRAIN_DIV  = 1
) (
    input  logic         clk,
    input  logic         reset,
    sim_console_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int PW    = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_ovf;
    logic                  r_en;
    logic [PW-1:0]         r_pace;
    logic                  r_exit_valid;
    logic [7:0]            r_exit_code;

    logic          w_wr_data;
    logic          w_wr_status;
    logic          w_wr_ctrl;
    logic          w_wr_exit;
    logic          w_empty;
    logic          w_full;
    logic          w_tx_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_overflow;
    logic [CW-1:0] w_cnt_next;
    logic          w_drained;
    logic          w_pending;
    logic [31:0]   w_rdata;

    assign w_wr_data   = bus.cs & bus.we & (bus.addr == 2'd0);
    assign w_wr_status = bus.cs & bus.we & (bus.addr == 2'd1);
    assign w_wr_ctrl   = bus.cs & bus.we & (bus.addr == 2'd2);
    assign w_wr_exit   = bus.cs & bus.we & (bus.addr == 2'd3);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_tx_valid = r_en & ~w_empty & (r_pace == '0) & (r_state != ST_DONE);
    assign w_pop      = w_tx_valid & bus.tx_ready;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted.
    assign w_push     = w_wr_data & (r_state != ST_DONE) & (~w_full | w_pop);
    assign w_overflow = w_wr_data & (r_state != ST_DONE) & w_full & ~w_pop;
    assign w_cnt_next = r_count + CW'(w_push) - CW'(w_pop);
    // With drain disabled the console never reports completion, even if already empty.
    assign w_drained  = r_en & (w_cnt_next == '0);
    assign w_pending  = (r_state == ST_DRAIN);

    // Control FSM: RUN until EXIT is written, DRAIN until the buffer empties, DONE until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_exit_valid <= 1'b0;
            r_exit_code  <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wr_exit) begin
                        r_exit_code <= bus.wdata[7:0];
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drained) begin
                        r_state      <= ST_DONE;
                        r_exit_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_exit_valid <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // FIFO pointers, fill count, sticky overflow, drain enable and pop pacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_en    <= 1'b1;
            r_pace  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            r_count <= w_cnt_next;
            // A new overflow in the same cycle as a clear wins, so no drop goes unreported.
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & bus.wdata[31]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_ctrl) begin
                r_en <= bus.wdata[0];
            end
            if (w_pop) begin
                r_pace <= PW'(DRAIN_DIV - 1);
            end else if (r_pace != '0) begin
                r_pace <= r_pace - PW'(1);
            end
        end
    end

    // Byte storage; contents need no reset because tx_data is only meaningful with tx_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.wdata[7:0];
        end
    end

    // Combinational register read-back.
    always_comb begin
        w_rdata = 32'd0;
        if (bus.cs) begin
            case (bus.addr)
                2'd1:    w_rdata = {r_ovf, 12'd0, w_pending, w_full, w_empty,
                                    {(16 - CW){1'b0}}, r_count};
                2'd2:    w_rdata = {31'd0, r_en};
                2'd3:    w_rdata = {24'd0, r_exit_code};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.rdata      = w_rdata;
    assign bus.tx_valid   = w_tx_valid;
    assign bus.tx_data    = r_mem[r_rptr];
    assign bus.exit_valid = r_exit_valid;
    assign bus.exit_code  = r_exit_code;

`ifdef SIM_CONSOLE_PRINT_EN
    // Simulation echo of drained bytes and program exit.
    always @(posedge clk) begin
        if (!reset) begin
            if (w_pop) begin
                $write("%c", bus.tx_data);
            end
            if ((r_state == ST_DRAIN) && w_drained) begin
                $display("EXIT %0d", r_exit_code);
                $finish;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_console.sv
// tb/tb_sim_console.sv - scoreboard bench for sim_console (depth 4, drain divisors 1 and 3)
module tb_sim_console;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         prev_b = -1;
    int         n_pop_b = 0;
    logic       pace_chk = 1'b0;

    sim_console_if bus_a ();
    sim_console_if bus_b ();

    sim_console #(.DEPTH_LOG2(2), .DRAIN_DIV(1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    sim_console #(.DEPTH_LOG2(2), .DRAIN_DIV(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Scoreboard side for instance A: every accepted pop must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && bus_a.tx_valid && bus_a.tx_ready) begin
            if (qa.size() == 0) check("a_unexpected_pop", 32'd1, 32'd0);
            else                check("a_pop_data", {24'd0, bus_a.tx_data}, {24'd0, qa.pop_front()});
        end
    end

    // Scoreboard side for instance B plus pacing of successive pops.
    always @(negedge clk) begin
        if (!reset) begin
            if (pace_chk && prev_b >= 0 && (cyc - prev_b) < 3)
                check("b_valid_low_between", {31'd0, bus_b.tx_valid}, 32'd0);
            if (bus_b.tx_valid && bus_b.tx_ready) begin
                if (qb.size() == 0) check("b_unexpected_pop", 32'd1, 32'd0);
                else                check("b_pop_data", {24'd0, bus_b.tx_data}, {24'd0, qb.pop_front()});
                if (pace_chk && prev_b >= 0) check("b_pace_gap", cyc - prev_b, 32'd3);
                prev_b = cyc;
                n_pop_b++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic c, input logic w,
                         input logic [1:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.cs = c; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
        end else begin
            bus_b.cs = c; bus_b.we = w; bus_b.addr = a; bus_b.wdata = d;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) bus_a.tx_ready = r;
        else          bus_b.tx_ready = r;
    endtask

    task automatic reg_write(input int sel, input logic [1:0] a, input logic [31:0] d);
        drive(sel, 1'b1, 1'b1, a, d);
        step();
        drive(sel, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic reg_read(input int sel, input logic [1:0] a, output logic [31:0] d);
        drive(sel, 1'b1, 1'b0, a, 32'd0);
        #1;
        d = (sel == 0) ? bus_a.rdata : bus_b.rdata;
        drive(sel, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic check_reg(input int sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        reg_read(sel, a, v);
        check(tag, v, exp);
    endtask

    task automatic push_byte(input int sel, input logic [7:0] b, input logic accept);
        if (accept) begin
            if (sel == 0) qa.push_back(b);
            else          qb.push_back(b);
        end
        reg_write(sel, 2'd0, {24'd0, b});
    endtask

    task automatic wait_drain(input int sel);
        for (int i = 0; i < 60; i++) begin
            if (((sel == 0) ? qa.size() : qb.size()) == 0) break;
            step();
        end
        check("drain_complete", (sel == 0) ? qa.size() : qb.size(), 32'd0);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lp;
        int ev;
        drive(0, 1'b0, 1'b0, 2'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 32'd0);
        set_ready(0, 1'b0);
        set_ready(1, 1'b0);
        do_reset();

        // Reset state
        check_reg(0, 2'd1, 32'h0001_0000, "rst_status");
        check_reg(0, 2'd2, 32'h0000_0001, "rst_ctrl");
        check_reg(0, 2'd3, 32'h0000_0000, "rst_exit");
        check_reg(0, 2'd0, 32'h0000_0000, "data_reads_zero");
        check("rst_tx_valid", {31'd0, bus_a.tx_valid}, 32'd0);
        check("rst_exit_valid", {31'd0, bus_a.exit_valid}, 32'd0);
        check("rdata_no_cs", bus_a.rdata, 32'd0);

        // Two bytes with the sink always ready
        set_ready(0, 1'b1);
        push_byte(0, 8'h48, 1'b1);
        push_byte(0, 8'h69, 1'b1);
        wait_drain(0);
        check_reg(0, 2'd1, 32'h0001_0000, "hi_status_after");

        // Overflow: five writes into a depth-4 FIFO with the sink stalled
        set_ready(0, 1'b0);
        for (int i = 0; i < 5; i++) push_byte(0, 8'h10 + 8'(i), i < 4);
        check_reg(0, 2'd1, 32'h8002_0004, "ovf_status");
        check("ovf_tx_valid", {31'd0, bus_a.tx_valid}, 32'd1);
        check("ovf_head", {24'd0, bus_a.tx_data}, 32'h10);
        set_ready(0, 1'b1);
        wait_drain(0);
        set_ready(0, 1'b0);
        check_reg(0, 2'd1, 32'h8001_0000, "ovf_sticky");
        reg_write(0, 2'd1, 32'h8000_0000);
        check_reg(0, 2'd1, 32'h0001_0000, "ovf_cleared");

        // Full FIFO with a simultaneous write and pop
        for (int i = 0; i < 4; i++) push_byte(0, 8'hA0 + 8'(i), 1'b1);
        check_reg(0, 2'd1, 32'h0002_0004, "full_status");
        set_ready(0, 1'b1);
        push_byte(0, 8'hA4, 1'b1);
        set_ready(0, 1'b0);
        check_reg(0, 2'd1, 32'h0002_0004, "full_push_pop");
        set_ready(0, 1'b1);
        wait_drain(0);

        // Drain enable off holds the FIFO
        set_ready(0, 1'b0);
        reg_write(0, 2'd2, 32'd0);
        set_ready(0, 1'b1);
        push_byte(0, 8'h31, 1'b1);
        push_byte(0, 8'h32, 1'b1);
        step();
        check("dis_tx_valid", {31'd0, bus_a.tx_valid}, 32'd0);
        check_reg(0, 2'd1, 32'h0000_0002, "dis_status");
        check_reg(0, 2'd2, 32'h0000_0000, "dis_ctrl");
        reg_write(0, 2'd2, 32'd1);
        wait_drain(0);

        // Exit after two queued bytes
        set_ready(0, 1'b0);
        push_byte(0, 8'h41, 1'b1);
        push_byte(0, 8'h42, 1'b1);
        reg_write(0, 2'd3, 32'h2A);
        reg_write(0, 2'd3, 32'h55);
        check_reg(0, 2'd1, 32'h0004_0002, "exit_pending");
        check("exit_not_yet", {31'd0, bus_a.exit_valid}, 32'd0);
        set_ready(0, 1'b1);
        lp = -1;
        ev = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.exit_valid) begin
                ev = cyc;
                break;
            end
            if (bus_a.tx_valid && bus_a.tx_ready) lp = cyc;
        end
        check("exit_after_last_pop", ev, lp + 1);
        step();
        check("exit_code", {24'd0, bus_a.exit_code}, 32'h2A);
        check("exit_queue_empty", qa.size(), 32'd0);
        check_reg(0, 2'd3, 32'h0000_002A, "exit_reg");
        check_reg(0, 2'd1, 32'h0001_0000, "done_status");
        push_byte(0, 8'h99, 1'b0);
        step();
        check_reg(0, 2'd1, 32'h0001_0000, "done_drop_write");
        check("done_tx_valid", {31'd0, bus_a.tx_valid}, 32'd0);
        check("done_exit_held", {31'd0, bus_a.exit_valid}, 32'd1);

        // Reset in DRAIN with three bytes queued
        set_ready(0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) push_byte(0, 8'h61 + 8'(i), 1'b1);
        reg_write(0, 2'd2, 32'd0);
        reg_write(0, 2'd3, 32'h11);
        check_reg(0, 2'd1, 32'h0004_0003, "drain3_status");
        reset = 1'b1;
        qa.delete();
        step();
        reset = 1'b0;
        check_reg(0, 2'd1, 32'h0001_0000, "rst_mid_status");
        check_reg(0, 2'd2, 32'h0000_0001, "rst_mid_ctrl");
        check_reg(0, 2'd3, 32'h0000_0000, "rst_mid_exit");
        check("rst_mid_exit_valid", {31'd0, bus_a.exit_valid}, 32'd0);

        // Paced drain with DRAIN_DIV=3
        prev_b = -1;
        n_pop_b = 0;
        pace_chk = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(1, 8'hC0 + 8'(i), 1'b1);
        set_ready(1, 1'b1);
        wait_drain(1);
        pace_chk = 1'b0;
        check("b_pop_count", n_pop_b, 32'd3);
        set_ready(1, 1'b0);

        // Exit on an empty FIFO spends exactly one cycle in DRAIN
        reg_write(1, 2'd3, 32'h07);
        check("b_exit_n", {31'd0, bus_b.exit_valid}, 32'd0);
        check_reg(1, 2'd1, 32'h0005_0000, "b_exit_pending");
        step();
        check("b_exit_n1", {31'd0, bus_b.exit_valid}, 32'd1);
        check("b_exit_code", {24'd0, bus_b.exit_code}, 32'h07);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
